fifo_flags: RTL and testbench
=============================

FIFO_FLAGS -- requirements
Module: fifo_flags

Interface
REQ-001 Parameter DATA_W, default 8: data word width in bits, >= 1.
REQ-002 Parameter DEPTH, default 4: number of storage entries, >= 2, need not be a power of two.
REQ-003 Parameter AF_THRESH, default DEPTH-1: almost_full threshold, 1..DEPTH.
REQ-004 Parameter AE_THRESH, default 1: almost_empty threshold, 0..DEPTH-1.
REQ-005 Parameter FWFT, default 0: read mode. 0 = registered read, 1 = first-word-fall-through.
REQ-006 clk  input  1  single clock for the block; every register updates on the rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 wr_en  input  1  write request.
REQ-009 rd_en  input  1  read request.
REQ-010 clr_err  input  1  clears the sticky error flags.
REQ-011 data_in  input  DATA_W  write data.
REQ-012 data_out  output  DATA_W  read data.
REQ-013 full, empty  output  1 each  occupancy flags: count==DEPTH, count==0.
REQ-014 almost_full, almost_empty  output  1 each  count>=AF_THRESH, count<=AE_THRESH.
REQ-015 count  output  $clog2(DEPTH+1)  current occupancy.
REQ-016 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 A write is accepted iff wr_en && !full; data_in is stored at wr_ptr, and wr_ptr advances.
REQ-018 A read is accepted iff rd_en && !empty; rd_ptr advances.
REQ-019 Pointers wrap from DEPTH-1 to 0 explicitly; no reliance on power-of-two overflow.
REQ-020 count updates by the rule below; all flags derive from the registered count and change on the same edge as count.
- +1 on an accepted write only.
- -1 on an accepted read only.
- unchanged when both are accepted or neither is.
REQ-021 Full with wr_en && rd_en: the read is accepted, the write is dropped, overflow is set, and count goes to DEPTH-1.
REQ-022 Empty with wr_en && rd_en: the write is accepted, the read is rejected, underflow is set, and count goes to 1.
REQ-023 overflow sets on wr_en && full and holds until reset or clr_err; a dropped write changes no other state.
REQ-024 underflow sets on rd_en && empty and holds until reset or clr_err; data_out holds its value.
REQ-025 If clr_err and a new error occur in the same cycle, the flag ends set (set wins).
REQ-026 FWFT=0: on an accepted read, data_out loads the head entry at the clock edge (one-cycle latency); otherwise data_out holds.
REQ-027 FWFT=1: data_out continuously presents the head entry (combinational from storage and rd_ptr); an accepted read pops it.
- data_out is don't-care while empty.
- The first word written to an empty FIFO appears on data_out the cycle after the write edge.

Reset
REQ-028 When reset is high at a rising edge, the following registers are cleared: wr_ptr, rd_ptr, count, overflow, underflow, and the FWFT=0 data_out register (all to 0).
REQ-029 Post-reset outputs are:
- empty=1, full=0, almost_empty=1, almost_full=0, count=0, data_out=0.
- wr_en, rd_en and clr_err are ignored in the reset cycle.
REQ-030 Reset asserted mid-operation discards all stored entries; storage contents are not cleared.

Structure
REQ-031 Package fifo_pkg holds:
- the count-width function (clog2 of DEPTH+1);
- the read-mode constants FWFT_OFF and FWFT_ON.
REQ-032 One sub-module, fifo_mem: DEPTH x DATA_W storage, with a synchronous write port and a combinational read port addressed by rd_ptr.
REQ-033 Elaboration fails on illegal parameters:
- DEPTH<2;
- AF_THRESH outside 1..DEPTH;
- AE_THRESH outside 0..DEPTH-1.

Verification (DATA_W=8, DEPTH=4, AF_THRESH=3, AE_THRESH=1)
REQ-034 Fill and drain:
- Stimulus: write A0..A3, then read 4 times, FWFT=0.
- Response: count 1,2,3,4; almost_full at count=3; full at count=4; data_out A0..A3, each one cycle after its rd_en; empty and almost_empty at the end.
REQ-035 Overflow:
- Stimulus: with the FIFO full, write A4, then pulse clr_err.
- Response: overflow=1, count=4, A4 never read back; overflow=0 after clr_err.
- Stimulus: clr_err coincident with another full write.
- Response: overflow stays 1.
REQ-036 Underflow and simultaneous access:
- Stimulus: wr_en+rd_en while empty.
- Response: underflow=1, count=1.
- Stimulus: wr_en+rd_en at count=2.
- Response: count stays 2, ordering preserved.
- Stimulus: wr_en+rd_en while full.
- Response: count=3, overflow=1.
REQ-037 Wrap-around:
- Stimulus: 10 interleaved write/read pairs of A0..A9.
- Response: output order A0..A9 with no loss; pointers pass DEPTH-1 -> 0 at least twice.
REQ-038 FWFT=1:
- Stimulus: write B5 to an empty FIFO.
- Response: data_out=B5 the next cycle with no rd_en; after rd_en, empty=1.
REQ-039 Mid-operation reset:
- Stimulus: assert reset at count=3, one cycle.
- Response: next cycle count=0, empty=1, flags cleared, data_out=0; a subsequent write/read of C7 returns C7.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the fifo_flags block.
package fifo_pkg;

  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register storage: synchronous write, combinational read.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int PW     = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents intentionally not reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_flags.sv
// Single-clock FIFO with occupancy flags, sticky error flags and selectable
// registered or first-word-fall-through read mode.
module fifo_flags
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  parameter int FWFT      = FWFT_OFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic                     clr_err,
  input  logic [DATA_W-1:0]        data_in,
  output logic [DATA_W-1:0]        data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = $clog2(DEPTH);

  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_flags: DEPTH must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("fifo_flags: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("fifo_flags: AE_THRESH must be in 0..DEPTH-1");
  end

  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     cnt_q;
  logic              wr_acc, rd_acc;
  logic [DATA_W-1:0] mem_rdata;

  assign full         = (cnt_q == CW'(DEPTH));
  assign empty        = (cnt_q == '0);
  assign almost_full  = (cnt_q >= CW'(AF_THRESH));
  assign almost_empty = (cnt_q <= CW'(AE_THRESH));
  assign count        = cnt_q;

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt_q     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_acc, rd_acc})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      // A new error in the same cycle as clr_err leaves the flag set.
      overflow  <= (overflow  && !clr_err) || (wr_en && full);
      underflow <= (underflow && !clr_err) || (rd_en && empty);
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PW     (PW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  if (FWFT == FWFT_ON) begin : g_fwft
    assign data_out = mem_rdata;
  end else begin : g_reg
    logic [DATA_W-1:0] dout_q;
    always_ff @(posedge clk) begin
      if (reset)       dout_q <= '0;
      else if (rd_acc) dout_q <= mem_rdata;
    end
    assign data_out = dout_q;
  end

endmodule

// File: tb/tb_fifo_flags.sv
// Bench for fifo_flags: one registered-read and one FWFT instance share stimulus
// and are compared against a queue-based reference model.
module tb_fifo_flags;

  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] data_in = '0;

  logic [7:0] dout0, dout1;
  logic       full0, empty0, af0, ae0, ovf0, unf0;
  logic       full1, empty1, af1, ae1, ovf1, unf1;
  logic [2:0] cnt0, cnt1;

  always #5 clk = ~clk;

  fifo_flags #(.DATA_W(8), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) dut0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .clr_err(clr_err),
    .data_in(data_in), .data_out(dout0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(cnt0),
    .overflow(ovf0), .underflow(unf0));

  fifo_flags #(.DATA_W(8), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) dut1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .clr_err(clr_err),
    .data_in(data_in), .data_out(dout1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(cnt1),
    .overflow(ovf1), .underflow(unf1));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [7:0] q[$];
  bit         m_ovf, m_unf;
  logic [7:0] m_dout;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit wr, input bit rd, input bit clr,
                      input logic [7:0] d);
    bit was_full, was_empty;
    reset = rst; wr_en = wr; rd_en = rd; clr_err = clr; data_in = d;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_dout = '0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (rd && !was_empty) m_dout = q.pop_front();
      if (wr && !was_full)  q.push_back(d);
      m_ovf = (m_ovf && !clr) || (wr && was_full);
      m_unf = (m_unf && !clr) || (rd && was_empty);
    end
    #1;
    check("count",   cnt0,  q.size());
    check("full",    full0, q.size() == DEPTH);
    check("empty",   empty0, q.size() == 0);
    check("afull",   af0,   q.size() >= AF);
    check("aempty",  ae0,   q.size() <= AE);
    check("ovf",     ovf0,  m_ovf);
    check("unf",     unf0,  m_unf);
    check("dout",    dout0, m_dout);
    check("count_f", cnt1,  q.size());
    check("ovf_f",   ovf1,  m_ovf);
    check("unf_f",   unf1,  m_unf);
    if (q.size() != 0) check("dout_f", dout1, q[0]);
  endtask

  initial begin
    #1;
    step(1, 1, 1, 1, 8'hFF);
    step(0, 0, 0, 0, 8'h00);

    // Fill and drain
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 8'hA0 + 8'(i));
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 8'h00);
    check("dr_last", dout0, 8'hA3);

    // Overflow, clear, clear coincident with new overflow
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 8'hA0 + 8'(i));
    step(0, 1, 0, 0, 8'hA4);
    check("ovf_set", ovf0, 1);
    step(0, 0, 0, 1, 8'h00);
    check("ovf_clr", ovf0, 0);
    step(0, 1, 0, 1, 8'hA5);
    check("ovf_race", ovf0, 1);
    step(0, 1, 1, 0, 8'hA6);
    check("full_wr", cnt0, 3);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 8'h00);

    // Underflow via simultaneous access on empty, then simultaneous at count=2
    step(0, 1, 1, 1, 8'hB1);
    check("unf_cnt", cnt0, 1);
    step(0, 1, 0, 0, 8'hB2);
    step(0, 1, 1, 0, 8'hB3);
    check("sim_cnt", cnt0, 2);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 8'h00);

    // Wrap-around with interleaved pairs
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 0, 8'hA0 + 8'(i));
      step(0, 0, 1, 0, 8'h00);
      check("wrap", dout0, 8'hA0 + i);
    end

    // FWFT fall-through
    step(0, 1, 0, 0, 8'hB5);
    check("fwft_b5", dout1, 8'hB5);
    step(0, 0, 1, 0, 8'h00);
    check("fwft_empty", empty1, 1);

    // Mid-operation reset
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 8'hD0 + 8'(i));
    step(0, 1, 1, 0, 8'hD3);
    step(1, 1, 1, 0, 8'hEE);
    check("rst_dout", dout0, 0);
    step(0, 1, 0, 0, 8'hC7);
    step(0, 0, 1, 0, 8'h00);
    check("rst_c7", dout0, 8'hC7);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 55,
           $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 10,
           8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
